// File: rtl/approx_add_pkg.sv
// Shared definitions for the approximate-adder datapaths.
//   - default parameter values for the adder wrappers
//   - mode encoding carried alongside each transaction
//   - sat_add: saturating accumulate used by every statistics counter
package approx_add_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LOW_BITS = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_ACC_W    = 24;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOA   = 1'b1;

  // Adds inc to acc and clamps to the all-ones value of a w-bit counter.
  // Operands are zero-extended to 64 bits by the caller and the result is
  // truncated back to w bits, so one function serves every counter width.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int          w);
    logic [64:0] lim;
    logic [64:0] s;
    lim = (65'(1) << w) - 65'(1);
    s   = {1'b0, acc} + {1'b0, inc};
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/approx_add_loa.sv
// Lower-part-OR approximate adder core (purely combinational).
// Ports:
//   a_i, b_i      : WIDTH-bit operands
//   approx_sum_o  : LOA sum, low LOW_BITS bits ORed, upper part exact
//   exact_sum_o   : a + b
//   err_o         : |exact_sum_o - approx_sum_o|
module approx_add_loa
  import approx_add_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOW_BITS = DEF_LOW_BITS
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   approx_sum_o,
  output logic [WIDTH:0]   exact_sum_o,
  output logic [WIDTH:0]   err_o
);

  localparam int HI_W = WIDTH - LOW_BITS;

  logic [LOW_BITS-1:0] low;
  logic                carry;
  logic [HI_W:0]       high;

  assign exact_sum_o = {1'b0, a_i} + {1'b0, b_i};

  assign low   = a_i[LOW_BITS-1:0] | b_i[LOW_BITS-1:0];
  // The only carry LOA propagates upward is the AND of the top low-part bits.
  assign carry = a_i[LOW_BITS-1] & b_i[LOW_BITS-1];
  assign high  = {1'b0, a_i[WIDTH-1:LOW_BITS]} + {1'b0, b_i[WIDTH-1:LOW_BITS]}
               + {{HI_W{1'b0}}, carry};

  assign approx_sum_o = {high, low};

  // LOA can over- or under-estimate, so take the magnitude either way.
  assign err_o = (exact_sum_o >= approx_sum_o) ? (exact_sum_o - approx_sum_o)
                                               : (approx_sum_o - exact_sum_o);

endmodule

// File: rtl/approx_add_pipe.sv
// Two-stage valid/ready pipeline around the LOA core, with on-chip error
// statistics for characterising approximate arithmetic.
// Ports:
//   clk, rst                   : clock, async active-high reset
//   in_valid/in_ready          : operand handshake (in_a, in_b, in_approx)
//   out_valid/out_ready        : result handshake (out_sum, out_err, out_approx)
//   stat_clr                   : synchronous clear of statistics
//   stat_txn, stat_errcnt      : saturating transaction / erroneous-result counts
//   stat_errsum, stat_errmax   : saturating error sum / worst error
//
// Handshake: a transfer occurs on an edge where valid and ready are both 1.
// Both stages move together when advance = !s2_valid | out_ready; otherwise
// every stage holds, so out_* stay stable while out_valid=1 and out_ready=0.
// in_ready equals advance, so a full pipe accepts and emits in one cycle.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOW_BITS = DEF_LOW_BITS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  output logic             out_approx,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_txn,
  output logic [CNT_W-1:0] stat_errcnt,
  output logic [ACC_W-1:0] stat_errsum,
  output logic [WIDTH:0]   stat_errmax
);

  logic [WIDTH:0] loa_approx, loa_exact, loa_err;
  logic           advance, xfer;

  logic           s1_valid_q, s1_mode_q;
  logic [WIDTH:0] s1_approx_q, s1_exact_q, s1_err_q;

  logic           s2_valid_q, s2_mode_q;
  logic [WIDTH:0] s2_sum_q, s2_err_q;
  logic [WIDTH:0] s2_sum_d, s2_err_d;

  logic [CNT_W-1:0] stat_txn_q, stat_txn_d, txn_base;
  logic [CNT_W-1:0] stat_errcnt_q, stat_errcnt_d, errcnt_base;
  logic [ACC_W-1:0] stat_errsum_q, stat_errsum_d, errsum_base;
  logic [WIDTH:0]   stat_errmax_q, stat_errmax_d, errmax_base;

  approx_add_loa #(
    .WIDTH    (WIDTH),
    .LOW_BITS (LOW_BITS)
  ) u_loa (
    .a_i          (in_a),
    .b_i          (in_b),
    .approx_sum_o (loa_approx),
    .exact_sum_o  (loa_exact),
    .err_o        (loa_err)
  );

  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance;
  assign xfer     = s2_valid_q && out_ready;

  // Exact-mode results carry no error by definition.
  assign s2_sum_d = (s1_mode_q == MODE_EXACT) ? s1_exact_q : s1_approx_q;
  assign s2_err_d = (s1_mode_q == MODE_LOA) ? s1_err_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_EXACT;
      s1_approx_q <= '0;
      s1_exact_q  <= '0;
      s1_err_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= MODE_EXACT;
      s2_sum_q    <= '0;
      s2_err_q    <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q   <= in_approx;
        s1_approx_q <= loa_approx;
        s1_exact_q  <= loa_exact;
        s1_err_q    <= loa_err;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_q <= s1_mode_q;
        s2_sum_q  <= s2_sum_d;
        s2_err_q  <= s2_err_d;
      end
    end
  end

  // A clear coinciding with a transfer restarts the stats from that
  // transaction's contribution, so the clear is applied before accumulating.
  assign txn_base    = stat_clr ? '0 : stat_txn_q;
  assign errcnt_base = stat_clr ? '0 : stat_errcnt_q;
  assign errsum_base = stat_clr ? '0 : stat_errsum_q;
  assign errmax_base = stat_clr ? '0 : stat_errmax_q;

  always_comb begin
    stat_txn_d    = txn_base;
    stat_errcnt_d = errcnt_base;
    stat_errsum_d = errsum_base;
    stat_errmax_d = errmax_base;
    if (xfer) begin
      stat_txn_d    = CNT_W'(sat_add(64'(txn_base), 64'd1, CNT_W));
      stat_errcnt_d = CNT_W'(sat_add(64'(errcnt_base),
                                     (s2_err_q != '0) ? 64'd1 : 64'd0, CNT_W));
      stat_errsum_d = ACC_W'(sat_add(64'(errsum_base), 64'(s2_err_q), ACC_W));
      stat_errmax_d = (s2_err_q > errmax_base) ? s2_err_q : errmax_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_txn_q    <= '0;
      stat_errcnt_q <= '0;
      stat_errsum_q <= '0;
      stat_errmax_q <= '0;
    end else begin
      stat_txn_q    <= stat_txn_d;
      stat_errcnt_q <= stat_errcnt_d;
      stat_errsum_q <= stat_errsum_d;
      stat_errmax_q <= stat_errmax_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_sum     = s2_sum_q;
  assign out_err     = s2_err_q;
  assign out_approx  = s2_mode_q;
  assign stat_txn    = stat_txn_q;
  assign stat_errcnt = stat_errcnt_q;
  assign stat_errsum = stat_errsum_q;
  assign stat_errmax = stat_errmax_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: a default-width instance plus a second instance
// with CNT_W=2 / ACC_W=4 sharing all inputs to exercise counter saturation.
module tb_approx_add_pipe;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int EW = 2 * (W + 1) + 1;  // {approx, sum, err}

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_approx, out_ready, stat_clr;
  logic [W-1:0] in_a, in_b;

  logic         in_ready, out_valid, out_approx;
  logic [W:0]   out_sum, out_err, stat_errmax;
  logic [15:0]  stat_txn, stat_errcnt;
  logic [23:0]  stat_errsum;

  logic         s_in_ready, s_out_valid, s_out_approx;
  logic [W:0]   s_out_sum, s_out_err, s_stat_errmax;
  logic [1:0]   s_stat_txn, s_stat_errcnt;
  logic [3:0]   s_stat_errsum;

  int n_checks = 0;
  int n_errors = 0;
  int stall_seen = 0;
  logic stim_done;

  logic [EW-1:0] exp_q[$];
  logic [63:0]   m_txn, m_errcnt, m_errsum, m_errmax;

  always #5 clk = ~clk;

  approx_add_pipe #(.WIDTH(W), .LOW_BITS(L), .CNT_W(16), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_err(out_err), .out_approx(out_approx), .stat_clr(stat_clr),
    .stat_txn(stat_txn), .stat_errcnt(stat_errcnt),
    .stat_errsum(stat_errsum), .stat_errmax(stat_errmax)
  );

  approx_add_pipe #(.WIDTH(W), .LOW_BITS(L), .CNT_W(2), .ACC_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_err(s_out_err), .out_approx(s_out_approx), .stat_clr(stat_clr),
    .stat_txn(s_stat_txn), .stat_errcnt(s_stat_errcnt),
    .stat_errsum(s_stat_errsum), .stat_errmax(s_stat_errmax)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] lim(input logic [63:0] v, input logic [63:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference LOA written with integer shifts and masks.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic m);
    int ia, ib, ex, lo, c, hi, ap, sum, err;
    ia  = int'(a);
    ib  = int'(b);
    ex  = ia + ib;
    lo  = (ia | ib) & ((1 << L) - 1);
    c   = (ia >> (L - 1)) & (ib >> (L - 1)) & 1;
    hi  = (ia >> L) + (ib >> L) + c;
    ap  = (hi << L) | lo;
    sum = m ? ap : ex;
    err = !m ? 0 : (ap > ex) ? (ap - ex) : (ex - ap);
    return {m, 9'(sum), 9'(err)};
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "_txn"},      64'(stat_txn),      lim(m_txn, 64'hFFFF));
    check({tag, "_errcnt"},   64'(stat_errcnt),   lim(m_errcnt, 64'hFFFF));
    check({tag, "_errsum"},   64'(stat_errsum),   lim(m_errsum, 64'hFF_FFFF));
    check({tag, "_errmax"},   64'(stat_errmax),   m_errmax);
    check({tag, "_s_txn"},    64'(s_stat_txn),    lim(m_txn, 64'd3));
    check({tag, "_s_errcnt"}, 64'(s_stat_errcnt), lim(m_errcnt, 64'd3));
    check({tag, "_s_errsum"}, 64'(s_stat_errsum), lim(m_errsum, 64'd15));
    check({tag, "_s_errmax"}, 64'(s_stat_errmax), m_errmax);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic ok;
    int   n;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_approx = m;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (ok) exp_q.push_back(model(a, b, m));
    else check("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    m_txn = 0; m_errcnt = 0; m_errsum = 0; m_errmax = 0;
  endtask

  // Scoreboard / monitor on the falling edge.
  initial begin
    logic          stalled_prev;
    logic [W:0]    prev_sum, prev_err;
    logic          prev_approx;
    logic [EW-1:0] e;
    stalled_prev = 1'b0;
    prev_sum = '0; prev_err = '0; prev_approx = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          check("hold_valid",  64'(out_valid),  64'd1);
          check("hold_sum",    64'(out_sum),    64'(prev_sum));
          check("hold_err",    64'(out_err),    64'(prev_err));
          check("hold_approx", 64'(out_approx), 64'(prev_approx));
        end
        if (out_valid && !out_ready) begin
          check("in_ready_stall",   64'(in_ready),   64'd0);
          check("s_in_ready_stall", 64'(s_in_ready), 64'd0);
          stall_seen++;
          stalled_prev = 1'b1;
          prev_sum = out_sum; prev_err = out_err; prev_approx = out_approx;
        end else begin
          stalled_prev = 1'b0;
        end
        if (stat_clr) model_clear();
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_sum",    64'(out_sum),     64'(e[17:9]));
            check("out_err",    64'(out_err),     64'(e[8:0]));
            check("out_approx", 64'(out_approx),  64'(e[18]));
            check("s_out",      64'({s_out_valid, s_out_approx, s_out_sum, s_out_err}),
                                64'({1'b1, e}));
            m_txn++;
            if (e[8:0] != 0) m_errcnt++;
            m_errsum += 64'(e[8:0]);
            if (64'(e[8:0]) > m_errmax) m_errmax = 64'(e[8:0]);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0;
    out_ready = 1'b1; stat_clr = 1'b0; stim_done = 1'b0;
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'({out_sum, out_err, out_approx}), 64'd0);
    check_stats("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency and directed LOA cases.
    send(8'h0F, 8'h01, 1'b1);
    check("lat_s1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_s2", 64'(out_valid), 64'd1);
    send(8'h18, 8'h08, 1'b1);
    send(8'h18, 8'h08, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);
    drain();
    check("dir_txn",    64'(stat_txn),    64'd4);
    check("dir_errcnt", 64'(stat_errcnt), 64'd3);
    check("dir_errsum", 64'(stat_errsum), 64'd10);
    check("dir_errmax", 64'(stat_errmax), 64'd8);
    check_stats("dir");

    // Clear without a transfer.
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("clr_txn", 64'(stat_txn), 64'd0);
    check_stats("clr");

    // Backpressure: five transactions against a stalled output.
    out_ready = 1'b0;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(8'(i * 37 + 3), 8'(i * 11 + 200), i[0]);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_seen", 64'(stall_seen >= 3), 64'd1);
    check_stats("bp");

    // Clear coinciding with a transfer of err=8.
    out_ready = 1'b0;
    send(8'h18, 8'h08, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clrx_wait", 64'(out_valid), 64'd1);
    stat_clr  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("clrx_txn",    64'(stat_txn),    64'd1);
    check("clrx_errsum", 64'(stat_errsum), 64'd8);
    check("clrx_errmax", 64'(stat_errmax), 64'd8);
    check_stats("clrx");

    // Five more transfers: the CNT_W=2 instance saturates at 3.
    for (int i = 0; i < 5; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    drain();
    check("sat_txn", 64'(s_stat_txn), 64'd3);
    check_stats("sat");

    // Random stream with random output backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check_stats("rand");

    // Reset with two transactions in flight.
    send(8'h01, 8'h02, 1'b1);
    send(8'h03, 8'h04, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",   64'(out_valid),   64'd0);
    check("mid_rst_s_valid", 64'(s_out_valid), 64'd0);
    exp_q.delete();
    model_clear();
    check_stats("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h0F, 8'h01, 1'b1);
    drain();
    check("post_rst_txn", 64'(stat_txn), 64'd1);
    check_stats("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
